// File: rtl/int_pkg.sv
// Shared definitions for the 32-to-16 integer narrowing stream.
// Holds the beat/word widths, the unpacker state encoding and the
// classification helper that decides whether a word fits in one beat.
package int_pkg;

  localparam int OUT_W = 16;
  localparam int IN_W  = 2 * OUT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

  // A word fits in one beat when its upper half carries no information:
  // all zeros for unsigned, all copies of bit OUT_W-1 for signed.
  function automatic logic fits_half(input logic [IN_W-1:0] word,
                                     input logic            is_signed);
    logic [OUT_W-1:0] upper;
    logic             fits;
    upper = word[IN_W-1:OUT_W];
    if (is_signed) begin
      fits = (upper == {OUT_W{word[OUT_W-1]}});
    end else begin
      fits = (upper == {OUT_W{1'b0}});
    end
    return fits;
  endfunction

endpackage : int_pkg

// File: rtl/int_narrow_unpacker.sv
// Narrows 32-bit integer words onto a 16-bit valid/ready stream.
// Words whose upper half is a pure zero/sign extension leave as a single
// narrow beat; all others leave as two beats, low half first. Beat fields
// are held in flops so they stay stable under backpressure, and the
// input-ready path looks through the output handshake so back-to-back
// words flow without bubbles.
module int_narrow_unpacker #(
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*OUT_W-1:0] in_data,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_last,
  output logic               out_narrow,
  output logic               out_hi,
  output logic [CNT_W-1:0]   narrow_cnt,
  output logic [CNT_W-1:0]   wide_cnt
);

  localparam int IN_W = 2 * OUT_W;

  import int_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [IN_W-1:0]    word_q, word_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_narrow_q, out_narrow_d;
  logic               out_hi_q, out_hi_d;
  logic [CNT_W-1:0]   narrow_cnt_q, narrow_cnt_d;
  logic [CNT_W-1:0]   wide_cnt_q, wide_cnt_d;

  logic               beat_done_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               fits_s;
  logic               go_load_s;
  logic               go_hi_s;
  logic               go_idle_s;

  // Handshake decode: ready when empty or when the final beat leaves now.
  always_comb begin
    beat_done_s = out_valid_q && out_ready;
    in_ready_s  = (state_q == IDLE) || (beat_done_s && out_last_q);
    accept_s    = in_valid && in_ready_s;
    fits_s      = fits_half(in_data, in_signed);
  end

  // Next-state selection: which of load / advance-to-high / drain happens.
  always_comb begin
    go_load_s    = 1'b0;
    go_hi_s      = 1'b0;
    go_idle_s    = 1'b0;
    narrow_cnt_d = narrow_cnt_q;
    wide_cnt_d   = wide_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          go_load_s = 1'b1;
        end else begin
          go_idle_s = 1'b0;
        end
      end
      LO: begin
        if (beat_done_s) begin
          if (out_narrow_q) begin
            narrow_cnt_d = narrow_cnt_q + CNT_ONE;
            if (accept_s) begin
              go_load_s = 1'b1;
            end else begin
              go_idle_s = 1'b1;
            end
          end else begin
            go_hi_s = 1'b1;
          end
        end else begin
          go_idle_s = 1'b0;
        end
      end
      HI: begin
        if (beat_done_s) begin
          wide_cnt_d = wide_cnt_q + CNT_ONE;
          if (accept_s) begin
            go_load_s = 1'b1;
          end else begin
            go_idle_s = 1'b1;
          end
        end else begin
          go_idle_s = 1'b0;
        end
      end
      default: begin
        go_idle_s = 1'b1;
      end
    endcase
  end

  // Register next values: new word into LO, upper half into HI, or clear.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_narrow_d = out_narrow_q;
    out_hi_d     = out_hi_q;
    if (go_load_s) begin
      state_d      = LO;
      word_d       = in_data;
      out_valid_d  = 1'b1;
      out_data_d   = in_data[OUT_W-1:0];
      out_last_d   = fits_s;
      out_narrow_d = fits_s;
      out_hi_d     = 1'b0;
    end else if (go_hi_s) begin
      state_d      = HI;
      out_valid_d  = 1'b1;
      out_data_d   = word_q[IN_W-1:OUT_W];
      out_last_d   = 1'b1;
      out_narrow_d = 1'b0;
      out_hi_d     = 1'b1;
    end else if (go_idle_s) begin
      state_d      = IDLE;
      word_d       = {IN_W{1'b0}};
      out_valid_d  = 1'b0;
      out_data_d   = {OUT_W{1'b0}};
      out_last_d   = 1'b0;
      out_narrow_d = 1'b0;
      out_hi_d     = 1'b0;
    end else begin
      state_d      = state_q;
    end
  end

  // State, word and beat registers; reset drops any pending word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= {IN_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_data_q   <= {OUT_W{1'b0}};
      out_last_q   <= 1'b0;
      out_narrow_q <= 1'b0;
      out_hi_q     <= 1'b0;
      narrow_cnt_q <= {CNT_W{1'b0}};
      wide_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_narrow_q <= out_narrow_d;
      out_hi_q     <= out_hi_d;
      narrow_cnt_q <= narrow_cnt_d;
      wide_cnt_q   <= wide_cnt_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign out_narrow = out_narrow_q;
  assign out_hi     = out_hi_q;
  assign narrow_cnt = narrow_cnt_q;
  assign wide_cnt   = wide_cnt_q;

endmodule : int_narrow_unpacker

// File: tb/tb_int_narrow_unpacker.sv
// Directed bench for int_narrow_unpacker: narrow/wide classification,
// zero-bubble streaming, backpressure stability and asynchronous reset.
module tb_int_narrow_unpacker;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_narrow;
  logic        out_hi;
  logic [15:0] narrow_cnt;
  logic [15:0] wide_cnt;

  int checks_cnt;
  int fail_cnt;

  int_narrow_unpacker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_signed  (in_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_narrow (out_narrow),
    .out_hi     (out_hi),
    .narrow_cnt (narrow_cnt),
    .wide_cnt   (wide_cnt)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs and let combinational paths settle.
  task automatic drive(input logic v, input logic [31:0] d, input logic s,
                       input logic r);
    in_valid  = v;
    in_data   = d;
    in_signed = s;
    out_ready = r;
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [15:0] d,
                             input logic last, input logic narrow,
                             input logic hi, input logic rdy);
    check_eq({tag, ".valid"},  32'(out_valid),  32'd1);
    check_eq({tag, ".data"},   32'(out_data),   32'(d));
    check_eq({tag, ".last"},   32'(out_last),   32'(last));
    check_eq({tag, ".narrow"}, 32'(out_narrow), 32'(narrow));
    check_eq({tag, ".hi"},     32'(out_hi),     32'(hi));
    check_eq({tag, ".rdy"},    32'(in_ready),   32'(rdy));
  endtask

  task automatic expect_idle(input string tag, input logic [15:0] ncnt,
                             input logic [15:0] wcnt);
    check_eq({tag, ".valid"}, 32'(out_valid),  32'd0);
    check_eq({tag, ".rdy"},   32'(in_ready),   32'd1);
    check_eq({tag, ".ncnt"},  32'(narrow_cnt), 32'(ncnt));
    check_eq({tag, ".wcnt"},  32'(wide_cnt),   32'(wcnt));
  endtask

  // Offer one word from IDLE; it is accepted at the following edge.
  task automatic offer(input logic [31:0] d, input logic s);
    drive(1'b1, d, s, 1'b1);
    check_eq("offer.rdy", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 32'h0000_0000;
    in_signed  = 1'b0;
    out_ready  = 1'b0;
    #2;
    check_eq("rst.valid", 32'(out_valid),  32'd0);
    check_eq("rst.data",  32'(out_data),   32'd0);
    check_eq("rst.ncnt",  32'(narrow_cnt), 32'd0);
    check_eq("rst.wcnt",  32'(wide_cnt),   32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // Zero-extended word: one narrow beat.
    offer(32'h0000_1234, 1'b0);
    expect_beat("zx", 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_idle("zx.end", 16'd1, 16'd0);

    // Full-width unsigned word: low then high.
    offer(32'h1234_5678, 1'b0);
    expect_beat("wide.lo", 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_beat("wide.hi", 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_idle("wide.end", 16'd1, 16'd1);

    // All-ones signed fits; unsigned does not.
    offer(32'hFFFF_FFFF, 1'b1);
    expect_beat("s_ones", 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_idle("s_ones.end", 16'd2, 16'd1);

    offer(32'hFFFF_FFFF, 1'b0);
    expect_beat("u_ones.lo", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_beat("u_ones.hi", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_idle("u_ones.end", 16'd2, 16'd2);

    // 0x8000 as signed needs a zero upper half it does not sign-match.
    offer(32'h0000_8000, 1'b1);
    expect_beat("s8000.lo", 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_beat("s8000.hi", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_idle("s8000.end", 16'd2, 16'd3);

    // Back-to-back stream with no bubbles.
    offer(32'h0000_0000, 1'b1);
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    expect_beat("b2b.0", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b1);
    expect_beat("b2b.1", 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_beat("b2b.2", 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_beat("b2b.3", 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_idle("b2b.end", 16'd4, 16'd4);

    // Backpressure on the low beat holds everything stable.
    offer(32'h1234_5678, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0000_0000, 1'b0, 1'b0);
      expect_beat("bp.stall", 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_beat("bp.release", 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b0);
    expect_beat("bp.hi", 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b0);
    expect_beat("bp.hi_hold", 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("bp.wcnt", 32'(wide_cnt), 32'd4);

    // Asynchronous reset while the high beat is stalled.
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst.valid", 32'(out_valid),  32'd0);
    check_eq("arst.ncnt",  32'(narrow_cnt), 32'd0);
    check_eq("arst.wcnt",  32'(wide_cnt),   32'd0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    offer(32'h0000_1234, 1'b0);
    expect_beat("post", 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    expect_idle("post.end", 16'd1, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_int_narrow_unpacker

// File: doc/int_narrow_unpacker.md
Name: int_narrow_unpacker

Overview:
- Takes 32-bit integer words and emits them as 16-bit beats over a valid/ready stream.
- A word whose upper half is a pure zero extension (unsigned) or sign extension (signed) of its lower half goes out as one "narrow" beat.
- Any other word goes out as two beats, low half first.
- Sits between 32-bit integer result producers and 16-bit datapaths. It is the narrowing counterpart of 16-to-32 zero/sign extension.

Parameters:
- OUT_W, 16, beat width; IN_W is fixed at 2*OUT_W.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block accepts word this cycle
- in_data  in  32  integer word
- in_signed  in  1  1 = test for sign extension, 0 = test for zero extension; sampled with in_data
- out_valid  out  1  beat present
- out_ready  in  1  consumer accepts beat
- out_data  out  16  beat payload
- out_last  out  1  final beat of the word
- out_narrow  out  1  word fit in 16 bits (single-beat word)
- out_hi  out  1  beat carries the upper half
- narrow_cnt  out  CNT_W  count of narrow words emitted, wraps
- wide_cnt  out  CNT_W  count of two-beat words emitted, wraps

Behaviour:
- Reset (async, immediate): state IDLE, word register cleared, all outputs 0.
- Reset is not masked by handshake state. Asserting rst_n low mid-word drops the pending word with no partial flush. out_valid falls without waiting for a clock.
- Acceptance: a word is taken at an edge where in_valid && in_ready.
- Narrow test is computed at acceptance and registered with the word:
  - unsigned: in_data[31:16] == 0
  - signed: in_data[31:16] == {16{in_data[15]}}
- States:
  - IDLE: in_ready=1, out_valid=0. On accept: go to LO.
  - LO: out_valid=1, out_data=word[15:0], out_hi=0, out_narrow=narrow flag, out_last=narrow flag.
    - Narrow word, beat taken: increment narrow_cnt. With a new accept in the same cycle, stay in LO with the new word; otherwise go to IDLE.
    - Wide word, beat taken: go to HI.
  - HI: out_valid=1, out_data=word[31:16], out_hi=1, out_last=1, out_narrow=0.
    - Beat taken: increment wide_cnt. With a new accept in the same cycle, go to LO with the new word; otherwise go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is a combinational path from out_ready to in_ready and gives zero-bubble throughput.
- Latency: word accepted at edge N → first beat valid in the cycle after N.
- Throughput: 1 word/cycle narrow, 1 word/2 cycles wide.
- Backpressure: while out_valid && !out_ready, out_data, out_last, out_narrow and out_hi hold stable. in_ready is 0 in this case.
- Counters increment once per completed word. They wrap modulo 2^CNT_W and are cleared only by reset.
- in_signed affects classification only. The beats are raw bit slices, never re-extended.

Decomposition:
- Shared package int_pkg holds:
  - OUT_W and IN_W constants
  - the state enum {IDLE, LO, HI}
  - a function fits_half(word, signed) returning the narrow flag
- No sub-module; the classification function replaces one.

Test Plan:
- Zero-extension case: 32'h00001234, in_signed=0 → one beat 16'h1234, last=1, narrow=1, hi=0; narrow_cnt=1.
- Full-width word: 32'h12345678, in_signed=0 → beats 16'h5678 (last=0, hi=0) then 16'h1234 (last=1, hi=1); wide_cnt=1.
- Sign extension:
  - 32'hFFFFFFFF signed → single beat 16'hFFFF, narrow=1.
  - Same word unsigned → two beats FFFF, FFFF.
  - 32'h00008000 signed → two beats 8000, 0000.
- Back-to-back with out_ready held 1:
  - Stream 00000000, FFFFFFFF (signed), 12345678 → beats 0000, FFFF, 5678, 1234 on four consecutive cycles, no bubbles.
  - in_ready is 0 only in the cycle presenting 5678.
- Backpressure: hold out_ready=0 for 3 cycles during the 16'h5678 beat → data and flags stable, in_ready=0; beat completes when out_ready rises.
- Reset mid-word: drop rst_n while the HI beat is stalled → out_valid=0 immediately, counters 0. After release, a new word 32'h00001234 is handled normally.
